// File: rtl/lcd_pkg.sv
// Shared constants for the LCD command sequencer: panel opcodes, the FSM
// state encoding and the default object-code palette.
package lcd_pkg;

  localparam logic [7:0] SWRESET      = 8'h01;
  localparam logic [7:0] DISPOFF      = 8'h28;
  localparam logic [7:0] SLPOUT       = 8'h11;
  localparam logic [7:0] COLMOD       = 8'h3A;
  localparam logic [7:0] DISPON       = 8'h29;
  localparam logic [7:0] CASET        = 8'h2A;
  localparam logic [7:0] PASET        = 8'h2B;
  localparam logic [7:0] RAMWR        = 8'h2C;
  localparam logic [7:0] COLMOD_16BPP = 8'h55;

  typedef enum logic [2:0] {
    IDLE,
    INIT_BYTE,
    INIT_WAIT,
    WIN_BYTE,
    PIXEL,
    DONE
  } state_e;

  // RGB565 color of an object code at power-up.
  function automatic logic [15:0] default_color(input int unsigned code);
    case (code)
      0:       default_color = 16'hFFFF;
      1:       default_color = 16'h901E;
      2:       default_color = 16'h6815;
      3:       default_color = 16'hF800;
      4:       default_color = 16'h0814;
      default: default_color = 16'hFFFF;
    endcase
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Byte stream from the sequencer to the panel bus driver.
// Handshake: a byte (out_data, out_dcx) transfers on a clock edge where
// out_valid and out_ready are both high; once out_valid rises it stays high
// with out_data/out_dcx unchanged until that edge, and out_valid never
// depends combinationally on out_ready.
interface lcd_cmd_sequencer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_dcx;

  modport master (output out_valid, output out_data, output out_dcx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_dcx, output out_ready);
endinterface

// File: rtl/lcd_palette.sv
// Object code to RGB565 color. With LCD_PALETTE_WR_EN defined the palette is
// a writable register file reset to the default colors; otherwise it is a
// constant ROM.
module lcd_palette
  import lcd_pkg::*;
#(
  parameter int OBJ_BITS = 3
) (
`ifdef LCD_PALETTE_WR_EN
  input  logic                clk,
  input  logic                nrst,
  input  logic                pal_we,
  input  logic [OBJ_BITS-1:0] pal_addr,
  input  logic [15:0]         pal_data,
`endif
  input  logic [OBJ_BITS-1:0] obj_code,
  output logic [15:0]         color
);

`ifdef LCD_PALETTE_WR_EN
  localparam int N = 2**OBJ_BITS;
  logic [15:0] pal_q [N];
  logic [15:0] pal_d [N];

  // Apply a single-entry write to the palette image.
  always_comb begin
    pal_d = pal_q;
    if (pal_we) pal_d[pal_addr] = pal_data;
  end

  // Palette registers, reloaded with the default colors on reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < N; i++) pal_q[i] <= default_color(i);
    end else begin
      pal_q <= pal_d;
    end
  end

  // Read port.
  always_comb color = pal_q[obj_code];
`else
  // Constant ROM lookup.
  always_comb color = default_color(32'(obj_code));
`endif

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Byte-stream generator for an ILI9341-class panel: init sequence with timed
// pauses, then per-cell window setup, RAMWR and CELL_W*CELL_H RGB565 pixels.
// Optional macro LCD_PALETTE_WR_EN adds palette write ports.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int CELL_W     = 20,
  parameter int CELL_H     = 20,
  parameter int XY_BITS    = 4,
  parameter int OBJ_BITS   = 3,
  parameter int INIT_DELAY = 50000
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start_init,
  input  logic                start_cell,
  input  logic [XY_BITS-1:0]  x,
  input  logic [XY_BITS-1:0]  y,
  input  logic [OBJ_BITS-1:0] obj_code,
  lcd_cmd_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
`ifdef LCD_PALETTE_WR_EN
  input  logic                pal_we,
  input  logic [OBJ_BITS-1:0] pal_addr,
  input  logic [15:0]         pal_data,
`endif
  output state_e              dbg_state
);

  localparam int PIX_TOTAL = CELL_W * CELL_H;
  localparam int PIX_W     = $clog2(PIX_TOTAL + 1);
  localparam int WAIT_W    = $clog2(INIT_DELAY + 1);

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                phase_q, phase_d;
  logic [XY_BITS-1:0]  x_q, x_d, y_q, y_d;
  logic [OBJ_BITS-1:0] obj_q, obj_d;
  logic [15:0]         color_q, color_d;
  logic [15:0]         pal_color;
  logic [15:0]         sc, ec, sp, ep;
  logic                accept;

  lcd_palette #(.OBJ_BITS(OBJ_BITS)) u_palette (
`ifdef LCD_PALETTE_WR_EN
    .clk      (clk),
    .nrst     (nrst),
    .pal_we   (pal_we),
    .pal_addr (pal_addr),
    .pal_data (pal_data),
`endif
    .obj_code (obj_q),
    .color    (pal_color)
  );

  // Cell window corners in panel coordinates.
  always_comb begin
    sc = 16'(x_q) * 16'(CELL_W);
    ec = sc + 16'(CELL_W - 1);
    sp = 16'(y_q) * 16'(CELL_H);
    ep = sp + 16'(CELL_H - 1);
  end

  // Present the byte for the current state; valid comes from state alone.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.out_dcx   = 1'b0;
    case (state_q)
      INIT_BYTE: begin
        bus.out_valid = 1'b1;
        case (idx_q)
          4'd0:    bus.out_data = SWRESET;
          4'd1:    bus.out_data = DISPOFF;
          4'd2:    bus.out_data = SLPOUT;
          4'd3:    bus.out_data = COLMOD;
          4'd4:    begin bus.out_data = COLMOD_16BPP; bus.out_dcx = 1'b1; end
          default: bus.out_data = DISPON;
        endcase
      end
      WIN_BYTE: begin
        bus.out_valid = 1'b1;
        bus.out_dcx   = 1'b1;
        case (idx_q)
          4'd0:    begin bus.out_data = CASET; bus.out_dcx = 1'b0; end
          4'd1:    bus.out_data = sc[15:8];
          4'd2:    bus.out_data = sc[7:0];
          4'd3:    bus.out_data = ec[15:8];
          4'd4:    bus.out_data = ec[7:0];
          4'd5:    begin bus.out_data = PASET; bus.out_dcx = 1'b0; end
          4'd6:    bus.out_data = sp[15:8];
          4'd7:    bus.out_data = sp[7:0];
          4'd8:    bus.out_data = ep[15:8];
          4'd9:    bus.out_data = ep[7:0];
          default: begin bus.out_data = RAMWR; bus.out_dcx = 1'b0; end
        endcase
      end
      PIXEL: begin
        bus.out_valid = 1'b1;
        bus.out_dcx   = 1'b1;
        bus.out_data  = phase_q ? color_q[7:0] : color_q[15:8];
      end
      default: ;
    endcase
  end

  assign accept    = bus.out_valid & bus.out_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  // Next-state logic; pixel color is sampled whenever a high byte is about
  // to be presented so a palette write never splits a pixel.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    pix_d   = pix_q;
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    obj_d   = obj_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        if (start_init || start_cell) begin
          x_d     = x;
          y_d     = y;
          obj_d   = obj_code;
          idx_d   = 4'd0;
          state_d = start_init ? INIT_BYTE : WIN_BYTE;
        end
      end
      INIT_BYTE: begin
        if (accept) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd5) begin
            state_d = DONE;
          end else if (idx_q == 4'd0 || idx_q == 4'd2) begin
            wait_d  = '0;
            state_d = INIT_WAIT;
          end
        end
      end
      INIT_WAIT: begin
        if (wait_q == WAIT_W'(INIT_DELAY - 1)) state_d = INIT_BYTE;
        else                                   wait_d  = wait_q + 1'b1;
      end
      WIN_BYTE: begin
        if (accept) begin
          if (idx_q == 4'd10) begin
            pix_d   = '0;
            phase_d = 1'b0;
            color_d = pal_color;
            state_d = PIXEL;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PIXEL: begin
        if (accept) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            color_d = pal_color;
            if (pix_q == PIX_W'(PIX_TOTAL - 1)) state_d = DONE;
            else                                pix_d   = pix_q + 1'b1;
          end
        end
      end
      default: begin
        idx_d   = 4'd0;
        wait_d  = '0;
        pix_d   = '0;
        phase_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      pix_q   <= '0;
      phase_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      obj_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      pix_q   <= pix_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      obj_q   <= obj_d;
      color_q <= color_d;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with a byte scoreboard.
module tb_lcd_cmd_sequencer;
  import lcd_pkg::*;

  localparam int CW = 20;
  localparam int CH = 20;
  localparam int DLY = 10;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start_init = 1'b0;
  logic       start_cell = 1'b0;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic [2:0] obj_code = '0;
  logic       busy, done;
  state_e     dbg_state;
  logic       pal_we = 1'b0;
  logic [2:0] pal_addr = '0;
  logic [15:0] pal_data = '0;

  lcd_cmd_sequencer_if bus();

  lcd_cmd_sequencer #(
    .CELL_W(CW), .CELL_H(CH), .XY_BITS(4), .OBJ_BITS(3), .INIT_DELAY(DLY)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start_init (start_init),
    .start_cell (start_cell),
    .x          (x),
    .y          (y),
    .obj_code   (obj_code),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
`ifdef LCD_PALETTE_WR_EN
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         acc_q[$];
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int acc_cnt = 0;
  int extra_cnt = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  bit rand_mode = 0;
  bit pal_mode = 0;
  bit ready_level = 1;
  bit hold_v = 0;
  logic [8:0] hold_val = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_color(input int code);
    case (code)
      1:       return 16'h901E;
      2:       return 16'h6815;
      3:       return 16'hF800;
      4:       return 16'h0814;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h28});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h3A});
    exp_q.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b0, 8'h29});
  endtask

  task automatic push_window(input int cx, input int cy);
    logic [15:0] sc, ec, sp, ep;
    sc = 16'(cx * CW); ec = 16'(cx * CW + CW - 1);
    sp = 16'(cy * CH); ep = 16'(cy * CH + CH - 1);
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, sc[15:8]}); exp_q.push_back({1'b1, sc[7:0]});
    exp_q.push_back({1'b1, ec[15:8]}); exp_q.push_back({1'b1, ec[7:0]});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, sp[15:8]}); exp_q.push_back({1'b1, sp[7:0]});
    exp_q.push_back({1'b1, ep[15:8]}); exp_q.push_back({1'b1, ep[7:0]});
    exp_q.push_back({1'b0, 8'h2C});
  endtask

  task automatic push_cell(input int cx, input int cy, input int co);
    logic [15:0] c;
    push_window(cx, cy);
    c = model_color(co);
    for (int i = 0; i < CW * CH; i++) begin
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  // Ready driver: held level or pseudo-random backpressure.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Monitor: pops the scoreboard on each accepted byte, checks hold stability.
  always @(negedge clk) begin
    if (!nrst) begin
      hold_v = 0;
    end else begin
      if (hold_v)
        check("hold_stable", 32'({bus.out_valid, bus.out_dcx, bus.out_data}), 32'({1'b1, hold_val}));
      if (bus.out_valid && bus.out_ready) begin
        acc_cnt++;
        acc_q.push_back(cyc);
        if (pal_mode) got_q.push_back({bus.out_dcx, bus.out_data});
        else if (exp_q.size() > 0)
          check("byte", 32'({bus.out_dcx, bus.out_data}), 32'(exp_q.pop_front()));
        else extra_cnt++;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_val = {bus.out_dcx, bus.out_data};
    end
  end

  task automatic clear_stats();
    acc_cnt = 0; extra_cnt = 0; done_cnt = 0;
    acc_q.delete(); got_q.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic go_cell(input int cx, input int cy, input int co);
    @(posedge clk); #1;
    x = 4'(cx); y = 4'(cy); obj_code = 3'(co); start_cell = 1'b1;
    @(posedge clk); #1 start_cell = 1'b0;
  endtask

  initial begin
    int bad, sw;
    logic [15:0] c;

    // Reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_dcx", 32'(bus.out_dcx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1 nrst = 1'b1;

    // Init sequence, ready held high.
    clear_stats(); push_init();
    @(posedge clk); #1 start_init = 1'b1;
    @(posedge clk); #1 start_init = 1'b0;
    @(negedge clk);
    check("init_first_valid", 32'({bus.out_valid, busy}), 32'b11);
    wait_done("init", 200);
    check("init_count", 32'(acc_cnt), 32'd6);
    check("init_left", 32'(exp_q.size()), 32'd0);
    check("init_done_once", 32'(done_cnt), 32'd1);
    if (acc_q.size() == 6) begin
      check("init_gap1", 32'(acc_q[1] - acc_q[0]), 32'(DLY + 1));
      check("init_gap2", 32'(acc_q[3] - acc_q[2]), 32'(DLY + 1));
      check("init_done_lat", 32'(last_done_cyc - acc_q[5]), 32'd1);
    end

    // Cell 3,2 obj 3, full throughput.
    clear_stats(); push_cell(3, 2, 3);
    go_cell(3, 2, 3);
    @(negedge clk);
    check("cell_first_valid", 32'(bus.out_valid), 32'd1);
    wait_done("cell", 2000);
    check("cell_count", 32'(acc_cnt), 32'd811);
    check("cell_left", 32'(exp_q.size()), 32'd0);
    check("cell_done_once", 32'(done_cnt), 32'd1);
    check("cell_span", 32'(acc_q[$] - acc_q[0]), 32'd810);
    check("cell_done_lat", 32'(last_done_cyc - acc_q[$]), 32'd1);
    check("cell_idle", 32'({busy, bus.out_valid}), 32'd0);

    // Backpressure: same stream under random ready.
    clear_stats(); rand_mode = 1; push_cell(5, 7, 1);
    go_cell(5, 7, 1);
    wait_done("bp", 6000);
    rand_mode = 0;
    check("bp_count", 32'(acc_cnt), 32'd811);
    check("bp_left", 32'(exp_q.size()), 32'd0);
    check("bp_done_once", 32'(done_cnt), 32'd1);

    // Both requests together: init wins, cell request ignored while busy.
    clear_stats(); push_init();
    @(posedge clk); #1 start_init = 1'b1; start_cell = 1'b1; x = 4'd1; y = 4'd1; obj_code = 3'd2;
    @(posedge clk); #1 start_init = 1'b0;
    repeat (5) @(posedge clk);
    #1 start_cell = 1'b0;
    wait_done("both", 200);
    check("both_count", 32'(acc_cnt), 32'd6);
    check("both_left", 32'(exp_q.size()), 32'd0);
    check("both_extra", 32'(extra_cnt), 32'd0);
    check("both_idle", 32'(busy), 32'd0);

    // Reset in the middle of pixel 137.
    clear_stats(); push_cell(1, 1, 2);
    go_cell(1, 1, 2);
    for (int i = 0; i < 2000 && acc_cnt < 11 + 2 * 137; i++) @(negedge clk);
    check("mid_reached", 32'(acc_cnt >= 11 + 2 * 137), 32'd1);
    @(posedge clk); #1 nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    @(posedge clk); #1 nrst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);

    // Fresh cell after reset: origin, unlisted object code.
    clear_stats(); push_cell(0, 0, 7);
    go_cell(0, 0, 7);
    wait_done("origin", 2000);
    check("origin_count", 32'(acc_cnt), 32'd811);
    check("origin_left", 32'(exp_q.size()), 32'd0);

`ifdef LCD_PALETTE_WR_EN
    // Palette write mid-cell: switch happens on a pixel boundary.
    clear_stats(); pal_mode = 1; rand_mode = 1;
    go_cell(0, 1, 1);
    for (int i = 0; i < 4000 && acc_cnt < 11 + 2 * 100 + 1; i++) @(negedge clk);
    @(posedge clk); #1 pal_we = 1'b1; pal_addr = 3'd1; pal_data = 16'h07E0;
    @(posedge clk); #1 pal_we = 1'b0;
    wait_done("pal", 6000);
    rand_mode = 0; pal_mode = 0;
    push_window(0, 1);
    check("pal_count", 32'(got_q.size()), 32'd811);
    for (int i = 0; i < 11 && got_q.size() > 0; i++)
      check("pal_window", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    bad = 0; sw = 0;
    while (got_q.size() >= 2) begin
      logic [8:0] hi, lo;
      hi = got_q.pop_front(); lo = got_q.pop_front();
      c = {hi[7:0], lo[7:0]};
      if (!hi[8] || !lo[8]) bad++;
      if (c == 16'h07E0) sw = 1;
      else if (c != 16'h901E || sw == 1) bad++;
    end
    check("pal_no_split", 32'(bad), 32'd0);
    check("pal_switched", 32'(sw), 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
